// File: rtl/piso_parity_tx_pkg.sv
// piso_pkg: shared types and helpers for the parity serial transmitter
// and its matching receiver.
//   state_t      - transmitter frame state (IDLE, DATA, PARITY)
//   PARITY_EVEN  - ODD_PARITY value selecting even parity
//   PARITY_ODD   - ODD_PARITY value selecting odd parity
//   calc_parity  - parity bit for a data word (zero-extend words narrower
//                  than MAX_WORD)
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;
  localparam int MAX_WORD    = 32;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [MAX_WORD-1:0] word,
                                       input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/piso_parity_tx.sv
// piso_parity_tx: parallel-in/serial-out transmitter. Each accepted word
// is sent LSB-first followed by one parity bit, one bit per en strobe.
// A one-word holding buffer allows frames to abut with no idle gap.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   en         - bit-period strobe; the shifter only advances when high
//   din        - parallel data word
//   din_valid  - din is valid this cycle
//   din_ready  - a word can be accepted this cycle
//   out        - serial data (IDLE_LVL between frames)
//   busy       - a frame is in progress
//   done       - high in the cycle the parity bit retires
module piso_parity_tx
  import piso_pkg::*;
#(
  parameter int WORD       = 8,
  parameter int ODD_PARITY = 0,
  parameter int IDLE_LVL   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [WORD-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic            out,
  output logic            busy,
  output logic            done
);

  localparam int   CW       = (WORD > 1) ? $clog2(WORD) : 1;
  localparam logic ODD_BIT  = 1'(ODD_PARITY);
  localparam logic IDLE_BIT = 1'(IDLE_LVL);

  state_t          state_reg, state_next;
  logic [WORD-1:0] shift_reg;
  logic [WORD-1:0] shift_next;
  logic [WORD-1:0] hold_reg;
  logic            hold_valid_reg;
  logic [CW-1:0]   cnt_reg;
  logic            par_reg;
  // Low during reset and for the first clock after it, so din_ready
  // stays low while rst is asserted.
  logic            live_reg;

  logic            xfer;
  logic            idle;
  logic            retire;
  logic            last_bit;
  logic            load_hold;
  logic            load_din;
  logic            load;
  logic [WORD-1:0] load_word;

  assign din_ready  = live_reg && !hold_valid_reg;
  assign xfer       = din_valid && din_ready;
  assign idle       = (state_reg == IDLE);
  assign retire     = (state_reg == PARITY) && en;
  assign last_bit   = (cnt_reg == CW'(WORD-1));
  assign shift_next = shift_reg >> 1;

  // The shifter loads when it is free (idle, or the current frame retires
  // this cycle). A pending hold word has priority; otherwise a word being
  // accepted right now goes straight in, skipping the hold buffer.
  assign load_hold = hold_valid_reg && (idle || retire);
  assign load_din  = xfer && !hold_valid_reg && (idle || retire);
  assign load      = load_hold || load_din;
  assign load_word = load_hold ? hold_reg : din;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load) state_next = DATA;
      end
      DATA: begin
        if (en && last_bit) state_next = PARITY;
      end
      PARITY: begin
        if (en) state_next = load ? DATA : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    out  = IDLE_BIT;
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      DATA: begin
        out  = shift_reg[0];
        busy = 1'b1;
      end
      PARITY: begin
        out  = par_reg;
        busy = 1'b1;
        done = en;
      end
      default: ;
    endcase
  end

  // Datapath: shifter, bit counter, parity accumulator, hold buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg      <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      cnt_reg        <= '0;
      par_reg        <= 1'b0;
      live_reg       <= 1'b0;
    end else begin
      live_reg <= 1'b1;

      // The en strobe on a load edge is deliberately ignored so bit0
      // gets a full bit period.
      if (load) begin
        shift_reg <= load_word;
        cnt_reg   <= '0;
        par_reg   <= ODD_BIT ^ load_word[0];
      end else if ((state_reg == DATA) && en && !last_bit) begin
        shift_reg <= shift_next;
        cnt_reg   <= cnt_reg + CW'(1);
        par_reg   <= par_reg ^ shift_next[0];
      end

      if (xfer && !load_din) begin
        hold_reg <= din;
      end
      hold_valid_reg <= (hold_valid_reg && !load_hold) || (xfer && !load_din);
    end
  end

endmodule

// File: tb/tb_piso_parity_tx.sv
module tb_piso_parity_tx;
  import piso_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       rdy_e, out_e, busy_e, done_e;
  logic       rdy_o, out_o, busy_o, done_o;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_parity_tx #(.WORD(8), .ODD_PARITY(0), .IDLE_LVL(1)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy_e), .out(out_e), .busy(busy_e), .done(done_e)
  );

  piso_parity_tx #(.WORD(8), .ODD_PARITY(1), .IDLE_LVL(1)) dut_odd (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy_o), .out(out_o), .busy(busy_o), .done(done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word for a single clock; returns #1 after the accepting edge.
  task automatic load_word(input logic [7:0] w, input logic en_val);
    din = w;
    din_valid = 1'b1;
    en = en_val;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  // Called #1 after the load edge. Checks every cycle of the frame; en is
  // pulsed in the last clock of each per-clock bit period.
  task automatic tx_frame(input logic [7:0] w, input int per, input logic par,
                          input bit odd_dut, input bit hold_first);
    logic exp_bit, o, bs, d, r;
    for (int b = 0; b < 9; b++) begin
      for (int p = 0; p < per; p++) begin
        en = (p == per - 1);
        #1;
        exp_bit = (b < 8) ? w[b] : par;
        o  = odd_dut ? out_o  : out_e;
        bs = odd_dut ? busy_o : busy_e;
        d  = odd_dut ? done_o : done_e;
        r  = odd_dut ? rdy_o  : rdy_e;
        chk($sformatf("out w=%h b%0d", w, b), o, exp_bit);
        chk($sformatf("busy w=%h b%0d", w, b), bs, 1'b1);
        chk($sformatf("done w=%h b%0d", w, b), d, (b == 8 && p == per - 1));
        chk($sformatf("ready w=%h b%0d", w, b), r, !(hold_first && !(b == 0 && p == 0)));
        @(posedge clk); #1;
        if (hold_first) din_valid = 1'b0;
      end
    end
    $display("frame %h done (per=%0d odd=%0d)", w, per, odd_dut);
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, " out"}, out_e, 1'b1);
    chk({tag, " busy"}, busy_e, 1'b0);
    chk({tag, " done"}, done_e, 1'b0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] acc;
    logic [7:0] exp_w;
    int nb;
    int frames;
    int cyc;

    // Reset
    #1 rst = 1'b0;
    #1;
    chk("rst out", out_e, 1'b1);
    chk("rst busy", busy_e, 1'b0);
    chk("rst done", done_e, 1'b0);
    chk("rst ready", rdy_e, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready held", rdy_e, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready after release", rdy_e, 1'b1);

    // A5, even parity 0, en constant high (en on the load edge ignored)
    load_word(8'hA5, 1'b1);
    tx_frame(8'hA5, 1, 1'b0, 1'b0, 1'b0);
    chk_idle("after A5");

    // FF on the odd-parity instance: parity 1
    load_word(8'hFF, 1'b1);
    tx_frame(8'hFF, 1, 1'b1, 1'b1, 1'b0);
    chk_idle("after FF");

    // 01 on the even instance: parity 1
    load_word(8'h01, 1'b1);
    tx_frame(8'h01, 1, 1'b1, 1'b0, 1'b0);
    chk_idle("after 01");

    // 0F then F0 back-to-back; F0 waits in the hold buffer
    load_word(8'h0F, 1'b1);
    din = 8'hF0;
    din_valid = 1'b1;
    tx_frame(8'h0F, 1, 1'b0, 1'b0, 1'b1);
    tx_frame(8'hF0, 1, 1'b0, 1'b0, 1'b0);
    chk_idle("after F0");

    // 5A with en every 4th clock: 36-clock frame
    load_word(8'h5A, 1'b0);
    tx_frame(8'h5A, 4, 1'b0, 1'b0, 1'b0);
    chk_idle("after 5A");

    // Reset during bit3 of C3, then 3C transmits cleanly
    load_word(8'hC3, 1'b1);
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("C3 b%0d", b), out_e, 8'hC3 >> b & 8'h01);
      if (b < 3) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b0;
    #1;
    chk("midrst out", out_e, 1'b1);
    chk("midrst busy", busy_e, 1'b0);
    chk("midrst done", done_e, 1'b0);
    chk("midrst ready", rdy_e, 1'b0);
    $display("mid-frame reset applied");
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready after midrst", rdy_e, 1'b1);
    load_word(8'h3C, 1'b1);
    tx_frame(8'h3C, 1, 1'b0, 1'b0, 1'b0);
    chk_idle("after 3C");

    // Random words with din_valid held high; scoreboard by calc_parity
    en = 1'b1;
    nb = 0;
    acc = 8'h00;
    frames = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      din = 8'($urandom);
      din_valid = (cyc < 120);
      #1;
      if (din_valid && rdy_e) q.push_back(din);
      if (busy_e) begin
        if (!done_e) begin
          if (nb < 8) acc[nb] = out_e;
          nb++;
        end else begin
          exp_w = (q.size() > 0) ? q.pop_front() : 8'hxx;
          chk("sb bits", nb, 8);
          chk("sb data", acc, exp_w);
          chk("sb parity", out_e, calc_parity(32'(exp_w), 1'b0));
          $display("sb frame %0d: data %h parity %0d", frames, acc, out_e);
          frames++;
          nb = 0;
        end
      end
      @(posedge clk); #1;
      if (cyc >= 120 && q.size() == 0 && !busy_e) break;
    end
    din_valid = 1'b0;
    chk("sb drained", (q.size() == 0) && !busy_e, 1'b1);
    chk("sb frames seen", frames > 5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
